// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
package seg7_pkg;

  localparam int unsigned SEG_W = 8;

  // Active-high "all segments dark" pattern, before pin polarity is applied.
  localparam logic [SEG_W-1:0] SEG_OFF = 8'h00;

  // Glyphs for hex digits 0..F; bit6..0 = a..g, active-high.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  // Map an active-high segment pattern onto the pin polarity.
  function automatic logic [SEG_W-1:0] apply_pol(input logic [SEG_W-1:0] seg,
                                                 input logic active_low);
    return active_low ? ~seg : seg;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Nibble plus decimal point to active-high segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0]       nibble,
  input  logic             dp,
  output logic [SEG_W-1:0] seg_c
);

  // Table lookup with the decimal point on bit7.
  assign seg_c = {dp, SEG_TABLE[nibble]};

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with frame-synchronous value
// update, per-slot dead time and optional leading-zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter int unsigned SEG_ACTIVE_LOW = 0,
  parameter int unsigned DIG_ACTIVE_LOW = 1,
  parameter int unsigned BLANK_LEADING  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   in_value,
  input  logic [DIGITS-1:0]     in_dp,
  input  logic                  in_load,
  output logic [SEG_W-1:0]      out_seg,
  output logic [DIGITS-1:0]     out_dig,
  output logic                  out_frame
);

  localparam int unsigned VAL_W = 4 * DIGITS;
  localparam int unsigned DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  localparam logic SEG_AL   = (SEG_ACTIVE_LOW != 0);
  localparam logic DIG_AL   = (DIG_ACTIVE_LOW != 0);
  localparam logic BLANK_EN = (BLANK_LEADING != 0);

  localparam logic [SEG_W-1:0]  SEG_OFF_PIN = apply_pol(SEG_OFF, SEG_AL);
  localparam logic [DIGITS-1:0] DIG_OFF_PIN = {DIGITS{DIG_AL}};

  logic [DIV_W-1:0]  div_q,        div_nxt;
  logic [IDX_W-1:0]  idx_q,        idx_nxt;
  logic [VAL_W-1:0]  shadow_val_q, shadow_val_nxt;
  logic [DIGITS-1:0] shadow_dp_q,  shadow_dp_nxt;
  logic [VAL_W-1:0]  active_val_q, active_val_nxt;
  logic [DIGITS-1:0] active_dp_q,  active_dp_nxt;
  logic              pending_q,    pending_nxt;
  logic              started_q,    started_nxt;

  logic [SEG_W-1:0]  seg_nxt;
  logic [DIGITS-1:0] dig_nxt;
  logic              frame_nxt;

  logic              div_end;
  logic              frame_end;
  logic              dead;
  logic [DIGITS-1:0] blank_mask;
  logic [DIGITS-1:0] dig_hot;
  logic [3:0]        cur_nib;
  logic              cur_dp;
  logic              cur_blank;
  logic [SEG_W-1:0]  dec_seg_c;
  logic [SEG_W-1:0]  seg_act;

  assign div_end   = (div_q == DIV_LAST);
  assign frame_end = div_end && (idx_q == IDX_LAST);
  assign dead      = (div_q == '0);

  // State register for the scan counters, value buffers and output pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q        <= '0;
      idx_q        <= '0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      active_val_q <= '0;
      active_dp_q  <= '0;
      pending_q    <= 1'b0;
      started_q    <= 1'b0;
      out_seg      <= SEG_OFF_PIN;
      out_dig      <= DIG_OFF_PIN;
      out_frame    <= 1'b0;
    end else begin
      div_q        <= div_nxt;
      idx_q        <= idx_nxt;
      shadow_val_q <= shadow_val_nxt;
      shadow_dp_q  <= shadow_dp_nxt;
      active_val_q <= active_val_nxt;
      active_dp_q  <= active_dp_nxt;
      pending_q    <= pending_nxt;
      started_q    <= started_nxt;
      out_seg      <= seg_nxt;
      out_dig      <= dig_nxt;
      out_frame    <= frame_nxt;
    end
  end

  // Scan advance, shadow capture and frame-boundary commit of the display value.
  always_comb begin
    div_nxt        = div_q + DIV_W'(1);
    idx_nxt        = idx_q;
    shadow_val_nxt = shadow_val_q;
    shadow_dp_nxt  = shadow_dp_q;
    active_val_nxt = active_val_q;
    active_dp_nxt  = active_dp_q;
    pending_nxt    = pending_q;
    started_nxt    = started_q;

    if (div_end) begin
      div_nxt = '0;
      idx_nxt = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end

    if (in_load) begin
      shadow_val_nxt = in_value;
      shadow_dp_nxt  = in_dp;
      pending_nxt    = 1'b1;
    end

    // A load landing on the boundary bypasses the shadow so it shows this frame.
    if (frame_end) begin
      pending_nxt = 1'b0;
      started_nxt = 1'b1;
      if (in_load) begin
        active_val_nxt = in_value;
        active_dp_nxt  = in_dp;
      end else if (pending_q) begin
        active_val_nxt = shadow_val_q;
        active_dp_nxt  = shadow_dp_q;
      end
    end
  end

  // Leading-zero mask: blank from the top digit down until a nonzero nibble or dp.
  always_comb begin
    logic keep;
    blank_mask = '0;
    keep       = !BLANK_EN;
    for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
      if (active_val_q[4*k +: 4] != 4'h0 || active_dp_q[k]) begin
        keep = 1'b1;
      end
      blank_mask[k] = !keep;
    end
  end

  // Select the nibble, dp, blank flag and enable line for the current digit.
  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    dig_hot   = '0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_nib    = active_val_q[4*k +: 4];
        cur_dp     = active_dp_q[k];
        cur_blank  = blank_mask[k];
        dig_hot[k] = 1'b1;
      end
    end
  end

  seg7_hex_decode u_decode (
    .nibble (cur_nib),
    .dp     (cur_dp),
    .seg_c  (dec_seg_c)
  );

  // Pin values for the next cycle: dark during the dead slot cycle or when blanked.
  always_comb begin
    seg_act   = (dead || cur_blank) ? SEG_OFF : dec_seg_c;
    seg_nxt   = apply_pol(seg_act, SEG_AL);
    dig_nxt   = dead ? DIG_OFF_PIN : (DIG_AL ? ~dig_hot : dig_hot);
    frame_nxt = started_q && dead && (idx_q == '0);
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomised self-checking bench for seg7_scan_driver against a frame-level model.
module tb_seg7_scan_driver;

  localparam int D  = 4;
  localparam int RD = 4;
  localparam int F  = D * RD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_value = '0;
  logic [3:0]  in_dp = '0;
  logic        in_load = 1'b0;

  logic [7:0]  seg_a, seg_b;
  logic [3:0]  dig_a, dig_b;
  logic        frame_a, frame_b;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  string       phase = "init";

  int          load_c [$];
  logic [15:0] load_v [$];
  logic [3:0]  load_d [$];

  logic [7:0]  glyph [16] = '{8'h7E, 8'h30, 8'h6D, 8'h79, 8'h33, 8'h5B, 8'h5F, 8'h70,
                              8'h7F, 8'h7B, 8'h77, 8'h1F, 8'h4E, 8'h3D, 8'h4F, 8'h47};

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(1), .BLANK_LEADING(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_value(in_value), .in_dp(in_dp), .in_load(in_load),
    .out_seg(seg_a), .out_dig(dig_a), .out_frame(frame_a)
  );

  seg7_scan_driver #(
    .DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1), .BLANK_LEADING(0)
  ) dut_al (
    .clk(clk), .rst_n(rst_n), .in_value(in_value), .in_dp(in_dp), .in_load(in_load),
    .out_seg(seg_b), .out_dig(dig_b), .out_frame(frame_b)
  );

  // Expected pins for cycle t: value shown in frame f is the last load made before f began.
  function automatic void model(input int t, input bit al, input bit blank_en,
                                output logic [7:0] seg, output logic [3:0] dig,
                                output logic frm);
    int          f   = t / F;
    int          pos = t % RD;
    int          k   = (t / RD) % D;
    logic [15:0] val = '0;
    logic [3:0]  dpv = '0;
    logic [15:0] sh;
    logic [7:0]  s;
    bit          blanked = 1'b0;
    for (int i = 0; i < load_c.size(); i++) begin
      if (load_c[i] < f * F) begin
        val = load_v[i];
        dpv = load_d[i];
      end
    end
    if (blank_en && k != 0) begin
      blanked = 1'b1;
      for (int j = k; j < D; j++) begin
        sh = val >> (4 * j);
        if (sh[3:0] != 4'h0 || dpv[j]) blanked = 1'b0;
      end
    end
    sh = val >> (4 * k);
    if (pos == 0 || blanked) s = 8'h00;
    else s = glyph[sh[3:0]] | {dpv[k], 7'b0};
    seg = al ? ~s : s;
    dig = (pos == 0) ? 4'hF : ~(4'b0001 << k);
    frm = (pos == 0 && k == 0 && f >= 1);
  endfunction

  // One clock: sample both instances on the falling edge and score them.
  task automatic step();
    logic [7:0] es;
    logic [3:0] ed;
    logic       ef;
    int         t;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    t = cyc - 1;
    model(t, 1'b0, 1'b1, es, ed, ef);
    checks += 3;
    if (seg_a !== es) begin errors++; $display("FAIL %s seg t=%0d got %h exp %h", phase, t, seg_a, es); end
    if (dig_a !== ed) begin errors++; $display("FAIL %s dig t=%0d got %h exp %h", phase, t, dig_a, ed); end
    if (frame_a !== ef) begin errors++; $display("FAIL %s frame t=%0d got %b exp %b", phase, t, frame_a, ef); end
    model(t, 1'b1, 1'b0, es, ed, ef);
    checks += 3;
    if (seg_b !== es) begin errors++; $display("FAIL %s al_seg t=%0d got %h exp %h", phase, t, seg_b, es); end
    if (dig_b !== ed) begin errors++; $display("FAIL %s al_dig t=%0d got %h exp %h", phase, t, dig_b, ed); end
    if (frame_b !== ef) begin errors++; $display("FAIL %s al_frame t=%0d got %b exp %b", phase, t, frame_b, ef); end
  endtask

  task automatic step_to(input int target);
    while (cyc - 1 < target) step();
  endtask

  task automatic align(input int m);
    while ((cyc % F) != m) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    in_value = v;
    in_dp    = d;
    in_load  = 1'b1;
    load_c.push_back(cyc);
    load_v.push_back(v);
    load_d.push_back(d);
    step();
    in_load = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    load_c.delete();
    load_v.delete();
    load_d.delete();
    cyc   = 0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    phase    = "reset";
    in_value = 16'h8888;
    in_load  = 1'b1;
    repeat (3) @(negedge clk);
    checks += 6;
    if (seg_a !== 8'h00) begin errors++; $display("FAIL reset seg got %h exp 00", seg_a); end
    if (dig_a !== 4'hF) begin errors++; $display("FAIL reset dig got %h exp F", dig_a); end
    if (frame_a !== 1'b0) begin errors++; $display("FAIL reset frame got %b exp 0", frame_a); end
    if (seg_b !== 8'hFF) begin errors++; $display("FAIL reset al_seg got %h exp FF", seg_b); end
    if (dig_b !== 4'hF) begin errors++; $display("FAIL reset al_dig got %h exp F", dig_b); end
    if (frame_b !== 1'b0) begin errors++; $display("FAIL reset al_frame got %b exp 0", frame_b); end
    in_load = 1'b0;
    release_reset();
    repeat (2 * F) step();
  endtask

  task automatic test_hex_1234();
    logic [7:0] exp_seg [4] = '{8'h33, 8'h79, 8'h6D, 8'h30};
    logic [3:0] exp_dig [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    int fc;
    phase = "hex1234";
    align(5);
    fc = cyc / F + 1;
    do_load(16'h1234, 4'h0);
    step_to(fc * F);
    checks += 3;
    if (seg_a !== 8'h00) begin errors++; $display("FAIL hex1234 dead_seg got %h exp 00", seg_a); end
    if (dig_a !== 4'hF) begin errors++; $display("FAIL hex1234 dead_dig got %h exp F", dig_a); end
    if (frame_a !== 1'b1) begin errors++; $display("FAIL hex1234 frame got %b exp 1", frame_a); end
    for (int i = 0; i < D; i++) begin
      step_to(fc * F + i * RD + 1);
      checks += 2;
      if (seg_a !== exp_seg[i]) begin errors++; $display("FAIL hex1234 digit%0d seg got %h exp %h", i, seg_a, exp_seg[i]); end
      if (dig_a !== exp_dig[i]) begin errors++; $display("FAIL hex1234 digit%0d dig got %h exp %h", i, dig_a, exp_dig[i]); end
    end
    repeat (F) step();
  endtask

  task automatic test_blanking();
    int fc;
    phase = "blank";
    fc = cyc / F + 1;
    do_load(16'h0050, 4'b0000);
    step_to(fc * F + 3 * RD + 1);
    checks++;
    if (seg_a !== 8'h00) begin errors++; $display("FAIL blank digit3 seg got %h exp 00", seg_a); end
    fc = cyc / F + 1;
    do_load(16'h0050, 4'b0100);
    step_to(fc * F + 2 * RD + 1);
    checks += 2;
    if (seg_a !== 8'hFE) begin errors++; $display("FAIL blank digit2_dp seg got %h exp FE", seg_a); end
    if (dig_a !== 4'hB) begin errors++; $display("FAIL blank digit2_dp dig got %h exp B", dig_a); end
    repeat (F) step();
  endtask

  task automatic test_last_wins();
    int fc;
    phase = "lastwins";
    align(2);
    fc = cyc / F + 1;
    do_load(16'hAAAA, 4'h0);
    step();
    do_load(16'hBEEF, 4'h0);
    for (int i = 0; i < D; i++) begin
      step_to(fc * F + i * RD + 1);
      checks++;
      if (seg_a === 8'h77) begin errors++; $display("FAIL lastwins digit%0d shows stale A got %h", i, seg_a); end
    end
    step_to(fc * F + 1);
    repeat (F) step();
  endtask

  task automatic test_boundary_load();
    int fc;
    phase = "boundary";
    align(F - 1);
    fc = cyc / F + 1;
    do_load(16'h0008, 4'h0);
    step_to(fc * F + 1);
    checks += 2;
    if (seg_a !== 8'h7F) begin errors++; $display("FAIL boundary digit0 seg got %h exp 7F", seg_a); end
    if (dig_a !== 4'hE) begin errors++; $display("FAIL boundary digit0 dig got %h exp E", dig_a); end
    repeat (F) step();
  endtask

  task automatic test_random();
    phase = "random";
    repeat (240) begin
      if ($urandom_range(0, 6) == 0) do_load(16'($urandom), 4'($urandom_range(0, 15)));
      else step();
    end
  endtask

  task automatic test_mid_reset();
    phase = "midreset";
    do_load(16'h9C3D, 4'b1010);
    repeat (5) step();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks += 4;
    if (seg_a !== 8'h00) begin errors++; $display("FAIL midreset seg got %h exp 00", seg_a); end
    if (dig_a !== 4'hF) begin errors++; $display("FAIL midreset dig got %h exp F", dig_a); end
    if (seg_b !== 8'hFF) begin errors++; $display("FAIL midreset al_seg got %h exp FF", seg_b); end
    if (frame_a !== 1'b0) begin errors++; $display("FAIL midreset frame got %b exp 0", frame_a); end
    release_reset();
    repeat (3 * F) step();
  endtask

  initial begin
    test_reset();
    test_hex_1234();
    test_blanking();
    test_last_wins();
    test_boundary_load();
    test_random();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
